// File: rtl/batch_1_mul_share_pkg.sv
// Shared widths and defaults for the batch_1 shared-multiplier block.
// Lane modules and the arbiter take their defaults from here.
package batch_1_mul_share_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_A_WIDTH    = 26;
   localparam int DEF_B_WIDTH    = 9;
   localparam int DEF_P_WIDTH    = DEF_A_WIDTH + DEF_B_WIDTH;
   localparam int DEF_ID_WIDTH   = 2;
   localparam int DEF_MUL_STAGES = 2;

endpackage

// File: rtl/batch_1_mul_share_pipe.sv
// Stallable signed(A) x unsigned(B) multiplier, MUL_STAGES deep, carrying valid and id.
// All stages shift together when en=1 and hold otherwise; bubbles are never squeezed out.
module batch_1_mul_share_pipe
   import batch_1_mul_share_pkg::*;
#(
   parameter int A_WIDTH    = DEF_A_WIDTH,
   parameter int B_WIDTH    = DEF_B_WIDTH,
   parameter int P_WIDTH    = DEF_P_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH,
   parameter int MUL_STAGES = DEF_MUL_STAGES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                in_valid,
   input  logic [ID_WIDTH-1:0] in_id,
   input  logic [A_WIDTH-1:0]  a,
   input  logic [B_WIDTH-1:0]  b,
   output logic                out_valid,
   output logic [ID_WIDTH-1:0] out_id,
   output logic [P_WIDTH-1:0]  p,
   output logic                any_valid
);

   logic signed [P_WIDTH-1:0] w_a_ext;
   logic signed [P_WIDTH-1:0] w_b_ext;
   logic signed [P_WIDTH-1:0] w_prod;

   logic                r_valid [MUL_STAGES];
   logic [ID_WIDTH-1:0] r_id    [MUL_STAGES];
   logic [P_WIDTH-1:0]  r_p     [MUL_STAGES];

   // B gets a zero sign bit so it multiplies as a non-negative value; the
   // product fits P_WIDTH exactly. Retiming spreads the array over the stages.
   assign w_a_ext = P_WIDTH'($signed(a));
   assign w_b_ext = P_WIDTH'({1'b0, b});
   assign w_prod  = w_a_ext * w_b_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: data stages are reset along with valids so the result port
         // reads zero after reset, not just invalid.
         for (int s = 0; s < MUL_STAGES; s++) begin
            r_valid[s] <= 1'b0;
            r_id[s]    <= '0;
            r_p[s]     <= '0;
         end
      end else if (en) begin
         r_valid[0] <= in_valid;
         r_id[0]    <= in_id;
         r_p[0]     <= w_prod;
         for (int s = 1; s < MUL_STAGES; s++) begin
            r_valid[s] <= r_valid[s-1];
            r_id[s]    <= r_id[s-1];
            r_p[s]     <= r_p[s-1];
         end
      end
   end

   always_comb begin
      any_valid = 1'b0;
      for (int s = 0; s < MUL_STAGES; s++) begin
         any_valid = any_valid | r_valid[s];
      end
   end

   assign out_valid = r_valid[MUL_STAGES-1];
   assign out_id    = r_id[MUL_STAGES-1];
   assign p         = r_p[MUL_STAGES-1];

endmodule

// File: rtl/batch_1_mul_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Results return on a single id-tagged valid/ready channel in acceptance order.
module batch_1_mul_share_arb
   import batch_1_mul_share_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int A_WIDTH    = DEF_A_WIDTH,
   parameter int B_WIDTH    = DEF_B_WIDTH,
   parameter int P_WIDTH    = DEF_P_WIDTH,
   parameter int MUL_STAGES = DEF_MUL_STAGES,
   parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [P_WIDTH-1:0]         resp_p,
   output logic [ID_WIDTH-1:0]        resp_id,
   output logic                       busy
);

   localparam int IDX_W = ID_WIDTH + 1;

   logic [ID_WIDTH-1:0] r_rr_ptr;
   logic                w_advance;
   logic                w_found;
   logic                w_xfer;
   logic [ID_WIDTH-1:0] w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic [A_WIDTH-1:0]  w_a;
   logic [B_WIDTH-1:0]  w_b;

   assign w_advance = !resp_valid || resp_ready;

   // Search upward from r_rr_ptr with wrap; the extra index bit keeps the
   // wrap subtraction correct when NUM_REQ is not a power of two.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path
      // through the loop can leave a latch behind.
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         w_idx = {1'b0, r_rr_ptr} + IDX_W'(off);
         if (w_idx >= IDX_W'(NUM_REQ)) begin
            w_idx = w_idx - IDX_W'(NUM_REQ);
         end
         if (!w_found && req_valid[w_idx[ID_WIDTH-1:0]]) begin
            w_found = 1'b1;
            w_grant = w_idx[ID_WIDTH-1:0];
         end
      end
   end

   assign w_xfer = w_found && w_advance && !ap_rst;

   always_comb begin
      req_ready = '0;
      if (w_xfer) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   assign w_a = req_a[int'(w_grant)*A_WIDTH +: A_WIDTH];
   assign w_b = req_b[int'(w_grant)*B_WIDTH +: B_WIDTH];

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_rr_ptr <= (w_grant == ID_WIDTH'(NUM_REQ-1)) ? '0 : w_grant + 1'b1;
      end
   end

   batch_1_mul_share_pipe #(
      .A_WIDTH    (A_WIDTH),
      .B_WIDTH    (B_WIDTH),
      .P_WIDTH    (P_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .MUL_STAGES (MUL_STAGES)
   ) u_pipe (
      .clk       (ap_clk),
      .rst       (ap_rst),
      .en        (w_advance),
      .in_valid  (w_xfer),
      .in_id     (w_grant),
      .a         (w_a),
      .b         (w_b),
      .out_valid (resp_valid),
      .out_id    (resp_id),
      .p         (resp_p),
      .any_valid (busy)
   );

endmodule

// File: tb/tb_batch_1_mul_share_arb.sv
// Bench for batch_1_mul_share_arb: directed scenarios and randomized traffic
// scored against a round-robin/queue model of the arbiter and multiplier.
module tb_batch_1_mul_share_arb;
   import batch_1_mul_share_pkg::*;

   localparam int N  = DEF_NUM_REQ;
   localparam int AW = DEF_A_WIDTH;
   localparam int BW = DEF_B_WIDTH;
   localparam int PW = DEF_P_WIDTH;
   localparam int IW = DEF_ID_WIDTH;
   localparam int MS = DEF_MUL_STAGES;

   typedef struct {
      int     id;
      longint p;
      int     cyc;
   } item_t;

   logic              ap_clk = 1'b0;
   logic              ap_rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_a;
   logic [N*BW-1:0]   req_b;
   logic              resp_valid;
   logic              resp_ready;
   logic [PW-1:0]     resp_p;
   logic [IW-1:0]     resp_id;
   logic              busy;

   int    checks    = 0;
   int    failures  = 0;
   int    cyc_cnt   = 0;
   int    bad_ready = 0;
   int    grant_q[$];
   item_t exp_q[$];
   item_t act_q[$];

   batch_1_mul_share_arb dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_p     (resp_p),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) cyc_cnt++;

   function automatic longint model_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
      return longint'($signed(a)) * longint'(b);
   endfunction

   // Records handshakes mid-cycle; the scenario tasks compare the records.
   always @(negedge ap_clk) begin
      item_t it;
      if (!ap_rst) begin
         if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) bad_ready++;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               grant_q.push_back(i);
               it.id  = i;
               it.p   = model_mul(req_a[i*AW +: AW], req_b[i*BW +: BW]);
               it.cyc = cyc_cnt;
               exp_q.push_back(it);
            end
         end
         if (resp_valid && resp_ready) begin
            it.id  = int'(resp_id);
            it.p   = longint'($signed(resp_p));
            it.cyc = cyc_cnt;
            act_q.push_back(it);
         end
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_op(input int i, input longint a, input longint b);
      req_a[i*AW +: AW] = AW'(a);
      req_b[i*BW +: BW] = BW'(b);
   endtask

   task automatic do_reset();
      ap_rst     = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b1;
      tick();
      tick();
      grant_q.delete();
      exp_q.delete();
      act_q.delete();
      ap_rst = 1'b0;
   endtask

   task automatic drain(input int n);
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (n) tick();
   endtask

   // Requesters hold until accepted, then pick a new random operation.
   task automatic refresh(input logic [N-1:0] acc, input int pct);
      for (int i = 0; i < N; i++) begin
         if (acc[i] || !req_valid[i]) begin
            req_valid[i] = (int'($urandom_range(0, 99)) < pct);
            case ($urandom_range(0, 7))
               0:       set_op(i, -33554432, 511);
               1:       set_op(i, 33554431, 511);
               2:       set_op(i, longint'($urandom), 0);
               default: set_op(i, longint'($urandom), longint'($urandom));
            endcase
         end
      end
   endtask

   task automatic test_reset();
      ap_rst     = 1'b1;
      req_valid  = '1;
      resp_ready = 1'b0;
      refresh('1, 100);
      req_valid  = '1;
      tick();
      checks++;
      if (req_ready !== '0) begin
         failures++;
         $display("FAIL reset_ready: got %b expected 0", req_ready);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (resp_p !== '0 || resp_id !== '0) begin
         failures++;
         $display("FAIL reset_data: got p=%0h id=%0d expected 0/0", resp_p, resp_id);
      end
      ap_rst    = 1'b0;
      req_valid = '0;
      tick();
   endtask

   task automatic test_single();
      int lat;
      do_reset();
      set_op(0, -3, 511);
      req_valid  = 4'b0001;
      resp_ready = 1'b1;
      @(negedge ap_clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_ready: got %b expected 0001", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL single_busy: got %b expected 1", busy);
      end
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != MS - 1) begin
         failures++;
         $display("FAIL single_latency: got %0d extra edges expected %0d", lat, MS - 1);
      end
      checks++;
      if (longint'($signed(resp_p)) != -1533 || resp_id !== 2'd0) begin
         failures++;
         $display("FAIL single_result: got p=%0d id=%0d expected -1533/0",
                  longint'($signed(resp_p)), resp_id);
      end
      tick();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_drain: got valid=%b busy=%b expected 0/0", resp_valid, busy);
      end
   endtask

   task automatic test_all_valid();
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
      req_valid  = '1;
      resp_ready = 1'b1;
      repeat (8) tick();
      drain(MS + 3);
      checks++;
      if (grant_q.size() != 8 || act_q.size() != 8) begin
         failures++;
         $display("FAIL rr_count: got grants=%0d results=%0d expected 8/8",
                  grant_q.size(), act_q.size());
      end
      for (int k = 0; k < 8 && k < grant_q.size() && k < act_q.size(); k++) begin
         checks++;
         if (grant_q[k] != k % N || act_q[k].id != k % N || act_q[k].p != longint'((k % N + 1) * 10)
             || act_q[k].cyc != act_q[0].cyc + k) begin
            failures++;
            $display("FAIL rr_order[%0d]: got grant=%0d id=%0d p=%0d cyc+%0d expected %0d/%0d/%0d/+%0d",
                     k, grant_q[k], act_q[k].id, act_q[k].p, act_q[k].cyc - act_q[0].cyc,
                     k % N, k % N, (k % N + 1) * 10, k);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] acc;
      do_reset();
      resp_ready = 1'b0;
      refresh('1, 100);
      req_valid = '1;
      repeat (3) begin
         @(negedge ap_clk);
         acc = req_valid & req_ready;
         tick();
         refresh(acc, 100);
      end
      checks++;
      if (resp_valid !== 1'b1 || exp_q.size() != MS) begin
         failures++;
         $display("FAIL bp_fill: got valid=%b accepted=%0d expected 1/%0d",
                  resp_valid, exp_q.size(), MS);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge ap_clk);
         checks++;
         if (exp_q.size() == 0 || req_ready !== '0 || resp_valid !== 1'b1 ||
             longint'($signed(resp_p)) != exp_q[0].p || int'(resp_id) != exp_q[0].id) begin
            failures++;
            $display("FAIL bp_hold[%0d]: got ready=%b valid=%b p=%0d id=%0d expected 0/1/%0d/%0d",
                     c, req_ready, resp_valid, longint'($signed(resp_p)), resp_id,
                     (exp_q.size() > 0) ? exp_q[0].p : 0, (exp_q.size() > 0) ? exp_q[0].id : -1);
         end
         tick();
      end
      resp_ready = 1'b1;
      repeat (6) begin
         @(negedge ap_clk);
         acc = req_valid & req_ready;
         tick();
         refresh(acc, 100);
      end
      drain(MS + 4);
      checks++;
      if (act_q.size() != exp_q.size() || exp_q.size() <= MS) begin
         failures++;
         $display("FAIL bp_count: got %0d results expected %0d", act_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
         checks++;
         if (act_q[k].id != exp_q[k].id || act_q[k].p != exp_q[k].p) begin
            failures++;
            $display("FAIL bp_data[%0d]: got id=%0d p=%0d expected id=%0d p=%0d",
                     k, act_q[k].id, act_q[k].p, exp_q[k].id, exp_q[k].p);
         end
      end
   endtask

   task automatic test_extremes();
      longint ea[4] = '{-33554432, 33554431, -1, -33554432};
      longint eb[4] = '{511, 511, 0, 0};
      longint ep[4] = '{-64'sd17146314752, 64'sd17146314241, 0, 0};
      do_reset();
      req_valid  = 4'b0001;
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_op(0, ea[k], eb[k]);
         @(negedge ap_clk);
         checks++;
         if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL ext_ready[%0d]: got %b expected 0001", k, req_ready);
         end
         tick();
      end
      drain(MS + 3);
      checks++;
      if (act_q.size() != 4) begin
         failures++;
         $display("FAIL ext_count: got %0d expected 4", act_q.size());
      end
      for (int k = 0; k < 4 && k < act_q.size(); k++) begin
         checks++;
         if (act_q[k].p != ep[k] || act_q[k].id != 0 || act_q[k].cyc != act_q[0].cyc + k) begin
            failures++;
            $display("FAIL ext_result[%0d]: got p=%0d id=%0d expected p=%0d id=0",
                     k, act_q[k].p, act_q[k].id, ep[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      refresh('1, 100);
      req_valid  = 4'b0011;
      resp_ready = 1'b1;
      tick();
      tick();
      ap_rst    = 1'b1;
      req_valid = '1;
      @(negedge ap_clk);
      checks++;
      if (req_ready !== '0) begin
         failures++;
         $display("FAIL mid_rst_ready: got %b expected 0", req_ready);
      end
      tick();
      ap_rst    = 1'b0;
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_state: got valid=%b busy=%b expected 0/0", resp_valid, busy);
      end
      grant_q.delete();
      exp_q.delete();
      act_q.delete();
      repeat (MS + 3) tick();
      checks++;
      if (act_q.size() != 0) begin
         failures++;
         $display("FAIL mid_stale: got %0d results expected 0", act_q.size());
      end
      req_valid = '1;
      @(negedge ap_clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL mid_ptr: got %b expected 0001", req_ready);
      end
      tick();
      req_valid = 4'b0100;
      @(negedge ap_clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL mid_req2_ready: got %b expected 0100", req_ready);
      end
      tick();
      drain(MS + 3);
      checks++;
      if (act_q.size() != 2 || exp_q.size() != 2) begin
         failures++;
         $display("FAIL mid_count: got %0d results expected 2", act_q.size());
      end else if (act_q[0].id != 0 || act_q[1].id != 2 ||
                   act_q[0].p != exp_q[0].p || act_q[1].p != exp_q[1].p) begin
         failures++;
         $display("FAIL mid_result: got ids %0d,%0d p %0d,%0d expected ids 0,2 p %0d,%0d",
                  act_q[0].id, act_q[1].id, act_q[0].p, act_q[1].p, exp_q[0].p, exp_q[1].p);
      end
   endtask

   task automatic test_fairness_skip();
      do_reset();
      refresh('1, 100);
      req_valid  = 4'b1010;
      resp_ready = 1'b1;
      repeat (6) tick();
      drain(MS + 3);
      checks++;
      if (grant_q.size() != 6) begin
         failures++;
         $display("FAIL skip_count: got %0d grants expected 6", grant_q.size());
      end
      for (int k = 0; k < 6 && k < grant_q.size(); k++) begin
         checks++;
         if (grant_q[k] != ((k % 2 == 0) ? 1 : 3)) begin
            failures++;
            $display("FAIL skip_order[%0d]: got %0d expected %0d", k, grant_q[k], (k % 2 == 0) ? 1 : 3);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] acc;
      logic [N-1:0] exp_rdy;
      int           m_ptr;
      int           m_next;
      int           rdy_fail;
      do_reset();
      m_ptr    = 0;
      m_next   = 0;
      rdy_fail = 0;
      refresh('1, 60);
      resp_ready = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge ap_clk);
         exp_rdy = '0;
         if (!resp_valid || resp_ready) begin
            for (int off = 0; off < N; off++) begin
               int k;
               k = (m_ptr + off) % N;
               if (req_valid[k]) begin
                  exp_rdy[k] = 1'b1;
                  m_next     = (k + 1) % N;
                  break;
               end
            end
         end
         checks++;
         if (req_ready !== exp_rdy) begin
            failures++;
            rdy_fail++;
            if (rdy_fail <= 5)
               $display("FAIL rand_grant[%0d]: got %b expected %b", c, req_ready, exp_rdy);
         end
         if (exp_rdy != '0) m_ptr = m_next;
         acc = req_valid & req_ready;
         tick();
         refresh(acc, 60);
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      drain(MS + 4);
      checks++;
      if (act_q.size() != exp_q.size() || exp_q.size() < 100) begin
         failures++;
         $display("FAIL rand_count: got %0d results expected %0d", act_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
         checks++;
         if (act_q[k].id != exp_q[k].id || act_q[k].p != exp_q[k].p) begin
            failures++;
            $display("FAIL rand_data[%0d]: got id=%0d p=%0d expected id=%0d p=%0d",
                     k, act_q[k].id, act_q[k].p, exp_q[k].id, exp_q[k].p);
         end
      end
      checks++;
      if (bad_ready != 0) begin
         failures++;
         $display("FAIL ready_onehot: got %0d bad cycles expected 0", bad_ready);
      end
   endtask

   initial begin
      ap_rst     = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      test_reset();
      test_single();
      test_all_valid();
      test_backpressure();
      test_extremes();
      test_reset_mid();
      test_fairness_skip();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/batch_1_mul_share_arb.md
Name: batch_1_mul_share_arb

Overview:
- Shares one pipelined signed×unsigned multiplier (26-bit signed A × 9-bit unsigned B → 35-bit signed P) among NUM_REQ requesters inside the batch_1 datapath.
- Arbitrates requests round-robin and tags each operation with its requester ID.
- Runs a stallable multiplier pipeline and returns results on one tagged output channel with valid/ready backpressure.
- Replaces per-lane multipliers where lane throughput is below one product per cycle.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- A_WIDTH, 26: signed multiplicand width.
- B_WIDTH, 9: unsigned multiplier width.
- P_WIDTH, 35: product width; must equal A_WIDTH+B_WIDTH (full precision, no truncation).
- MUL_STAGES, 2: register stages from accept to result, ≥1.
- ID_WIDTH, 2: requester tag width; must be ≥ clog2(NUM_REQ).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  flattened A operands; requester i at [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  flattened B operands; same slicing.
- resp_valid  out  1  result valid.
- resp_ready  in  1  downstream accepts result.
- resp_p  out  P_WIDTH  product.
- resp_id  out  ID_WIDTH  requester index of the product.
- busy  out  1  any pipeline stage holds a valid operation.

Behaviour:
- Arithmetic: P = $signed(A) * $signed({1'b0,B}). Full-width result, never saturated or truncated.
- Pipeline:
  - MUL_STAGES stages, each holding valid, id, and operands or partial/final product.
  - The last stage drives resp_valid, resp_p and resp_id.
  - advance = !resp_valid || resp_ready. All stages shift together only when advance=1; otherwise every stage holds.
  - Bubbles are not compressed, so the pipeline is a strict shift register.
- Arbitration:
  - Combinational grant over req_valid, searching from rr_ptr upward with modulo wrap; the first valid index k wins.
  - req_ready[k] = advance && req_valid[k]. All other req_ready bits are 0.
  - A transfer occurs when req_valid[i] && req_ready[i]. The selected operands and id=k enter stage 1.
  - If advance=1 and no request is valid, a bubble (valid=0) enters stage 1.
  - On a transfer of k: rr_ptr <= (k+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Latency: a request accepted at edge t gives resp_valid=1 after edge t+MUL_STAGES-1, i.e. visible for handshake on cycle t+MUL_STAGES, with no stalls. Throughput is one product per cycle.
- Backpressure:
  - While resp_valid && !resp_ready, resp_p and resp_id stay stable and no req_ready is asserted.
  - The result transfers on the first cycle with resp_ready=1. The same cycle can accept a new request.
- Ordering: results leave in acceptance order. Each requester's results are in its own issue order.
- Requester obligation: hold req_valid and operands until accepted. The block does not latch unaccepted requests.
- busy = OR of all stage valids.
- Reset (ap_rst=1 at an edge, including mid-operation):
  - All stage valids cleared; in-flight operations are discarded with no response.
  - rr_ptr=0, resp_valid=0, resp_p=0, resp_id=0, busy=0.
  - req_ready=0 while ap_rst=1.
- Boundary cases:
  - All requesters valid: strict rotation 0,1,2,3,0,…
  - Single requester valid continuously: granted every cycle.
  - A=-2^25, B=511 must give exactly -17146314752.
  - B=0 gives P=0 for any A.

Decomposition:
- Shared package/header: default widths (A_WIDTH, B_WIDTH, P_WIDTH, ID_WIDTH) and the NUM_REQ default, so lane modules and this block agree.
- One sub-module: batch_1_mul_share_pipe.
  - Holds the stallable MUL_STAGES multiplier pipeline, with ports en, in_valid, in_id, a, b, out_valid, out_id, p.
  - The arbiter, rr_ptr and handshake logic stay in the top.

Test Plan:
- Single request: req_valid=4'b0001, A=-3, B=511 → req_ready[0] same cycle; resp_p=-1533, resp_id=0, resp_valid exactly MUL_STAGES cycles later; busy=1 meanwhile.
- All four valid for 8 cycles, A=i+1, B=10, resp_ready=1 → grant order 0,1,2,3,0,1,2,3; products 10,20,30,40 repeating; one result per cycle.
- Backpressure: pipeline full, resp_ready=0 for 5 cycles → resp_p and resp_id stable, req_ready=0; after release, results drain in order with no loss or duplication.
- Extremes: A=-33554432/B=511 → -17146314752; A=33554431/B=511 → 17146314241; A=-1/B=0 → 0.
- Reset mid-operation: two ops in flight, assert ap_rst one cycle → resp_valid=0, busy=0, rr_ptr=0; no stale result emerges afterwards; next request from requester 2 is granted with resp_id=2.
- Fairness skip: req_valid=4'b1010 constant → grants alternate 1,3,1,3, starting with 1 from rr_ptr=0.
